// File: rtl/ldst_pkg.sv
// ldst_pkg: shared types and constants for the load/store controller.
//   ldst_op_e       command opcode (LDR = 0, STR = 1)
//   ldst_state_e    sequencer states
//   LDST_ALIGN_MASK byte-offset bits that must be zero for a word access
package ldst_pkg;

    typedef enum logic {
        LDR = 1'b0,
        STR = 1'b1
    } ldst_op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WB,
        FETCH,
        WR,
        ERR
    } ldst_state_e;

    localparam logic [1:0] LDST_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & LDST_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ldst_wait_counter.sv
// ldst_wait_counter: load-and-count-down counter that paces the RAM read
// latency. Loaded with (latency - 1) on the cycle before counting starts,
// it then decrements while en is high and saturates at zero.
//   clk, rst  clock and synchronous active-high reset
//   load      load load_val (has priority over counting)
//   en        decrement while nonzero
//   load_val  value to load
//   zero      counter currently holds zero
module ldst_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ldst_controller.sv
// ldst_controller: serial sequencer for LDR/STR commands between the decode
// stage and the RAM / GPR bank. One command is in flight at a time.
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; fields sampled on transfer
//   cmd_op/reg/addr     opcode, GPR index, word-aligned byte address
//   mem_ldr/mem_str     RAM read / write strobes
//   mem_addr/wdata      RAM address and write data (held between commands)
//   mem_rdata           RAM read data, valid RD_LAT cycles after mem_ldr
//   rf_rsel/rf_rdata    GPR read port (combinational read)
//   rf_we/wsel/wdata    GPR write port
//   done, err           completion pulse; err marks a misaligned command
module ldst_controller
    import ldst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [REG_W-1:0]  cmd_reg,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              mem_ldr,
    output logic              mem_str,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_W-1:0]  rf_rsel,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wsel,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              err
);

    localparam int                CNT_W     = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(RD_LAT - 1);

    ldst_state_e       state;
    ldst_state_e       state_nx;
    ldst_op_e          op_q;
    logic [REG_W-1:0]  reg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              xfer;
    logic              wait_zero;
    logic              capture;

    assign cmd_ready = (state == IDLE) && !rst;
    assign xfer      = cmd_valid && cmd_ready;

    ldst_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == RD),
        .en       (state == WAIT),
        .load_val (WAIT_LOAD),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (is_misaligned(cmd_addr[1:0])) begin
                        state_nx = ERR;
                    end else if (ldst_op_e'(cmd_op) == STR) begin
                        state_nx = FETCH;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:      state_nx = WAIT;
            WAIT:    if (wait_zero) state_nx = WB;
            FETCH:   state_nx = WR;
            WB,
            WR,
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One data register serves both directions: RAM data on the last WAIT
    // cycle of a load, GPR data in FETCH of a store.
    assign capture = ((state == WAIT) && wait_zero) || (state == FETCH);

    // NOTE: the datapath registers are small and drive held outputs, so they
    // are reset too; nothing large enough to be a memory lives here.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= LDR;
            reg_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (xfer) begin
                op_q   <= ldst_op_e'(cmd_op);
                reg_q  <= cmd_reg;
                addr_q <= cmd_addr;
            end
            if (capture) begin
                data_q <= (op_q == STR) ? rf_rdata : mem_rdata;
            end
        end
    end

    // Strobes come from the state register alone.
    always_comb begin
        mem_ldr = 1'b0;
        mem_str = 1'b0;
        rf_we   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            RD:  mem_ldr = 1'b1;
            WB: begin
                rf_we = 1'b1;
                done  = 1'b1;
            end
            WR: begin
                mem_str = 1'b1;
                done    = 1'b1;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign rf_rsel   = reg_q;
    assign rf_wsel   = reg_q;
    assign rf_wdata  = data_q;

endmodule
